// File: rtl/rmt_dest_demux.sv
// Frame-level AXI-Stream demux: tdest is latched on the first beat and the whole frame is steered to one output.
// Optional per-output frame and drop counters are enabled with `define RMT_DEMUX_STATS_EN.
module rmt_dest_demux #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = (DATA_WIDTH + 7) / 8,
    parameter int USER_WIDTH = 8,
    parameter int DEST_WIDTH = 2,
    parameter int M_COUNT    = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]         s_axis_tkeep,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    input  logic [USER_WIDTH-1:0]         s_axis_tuser,
    input  logic [DEST_WIDTH-1:0]         s_axis_tdest,
    output logic [M_COUNT*DATA_WIDTH-1:0] m_axis_tdata,
    output logic [M_COUNT*KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic [M_COUNT-1:0]            m_axis_tvalid,
    input  logic [M_COUNT-1:0]            m_axis_tready,
    output logic [M_COUNT-1:0]            m_axis_tlast,
    output logic [M_COUNT*USER_WIDTH-1:0] m_axis_tuser
`ifdef RMT_DEMUX_STATS_EN
    ,
    output logic [M_COUNT*32-1:0]         stat_frames,
    output logic [31:0]                   stat_drops
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } state_t;

    // One extra bit so M_COUNT == 2**DEST_WIDTH is representable.
    localparam logic [DEST_WIDTH:0] M_COUNT_W = (DEST_WIDTH + 1)'(M_COUNT);

    state_t                  state;
    state_t                  state_next;

    logic                    out_valid;
    logic [DEST_WIDTH-1:0]   out_sel;
    logic [DEST_WIDTH-1:0]   cur_sel;
    logic [DATA_WIDTH-1:0]   out_data;
    logic [KEEP_WIDTH-1:0]   out_keep;
    logic                    out_last;
    logic [USER_WIDTH-1:0]   out_user;

    logic                    sel_ready;
    logic                    dest_ok;
    logic                    accept;
    logic                    pop;
    logic                    load;
    logic [DEST_WIDTH-1:0]   load_sel;

    always_comb begin
        sel_ready = 1'b0;
        for (int i = 0; i < M_COUNT; i++) begin
            if (out_sel == DEST_WIDTH'(i)) begin
                sel_ready = m_axis_tready[i];
            end
        end
    end

    always_comb begin
        dest_ok  = {1'b0, s_axis_tdest} < M_COUNT_W;
        accept   = s_axis_tvalid && s_axis_tready;
        pop      = out_valid && sel_ready;
        load     = accept && (((state == IDLE) && dest_ok) || (state == FWD));
        load_sel = (state == IDLE) ? s_axis_tdest : cur_sel;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && !s_axis_tlast) begin
                    state_next = dest_ok ? FWD : DROP;
                end
            end
            FWD, DROP: begin
                if (accept && s_axis_tlast) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output register: a load replaces the held beat, so pop+load keeps out_valid high.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_sel   <= '0;
            cur_sel   <= '0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
            out_user  <= '0;
        end else begin
            if (accept && (state == IDLE) && dest_ok) begin
                cur_sel <= s_axis_tdest;
            end
            if (load) begin
                out_valid <= 1'b1;
                out_sel   <= load_sel;
                out_data  <= s_axis_tdata;
                out_keep  <= s_axis_tkeep;
                out_last  <= s_axis_tlast;
                out_user  <= s_axis_tuser;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Output logic
    always_comb begin
        s_axis_tready = rst && ((state == DROP) || !out_valid || sel_ready);
        m_axis_tvalid = '0;
        for (int i = 0; i < M_COUNT; i++) begin
            m_axis_tvalid[i] = out_valid && (out_sel == DEST_WIDTH'(i));
        end
        m_axis_tdata = {M_COUNT{out_data}};
        m_axis_tkeep = {M_COUNT{out_keep}};
        m_axis_tlast = {M_COUNT{out_last}};
        m_axis_tuser = {M_COUNT{out_user}};
    end

`ifdef RMT_DEMUX_STATS_EN
    logic [31:0] frame_cnt [M_COUNT];

    // Frames are counted when their last beat leaves; drops when an out-of-range first beat arrives.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < M_COUNT; i++) begin
                frame_cnt[i] <= '0;
            end
            stat_drops <= '0;
        end else begin
            if (pop && out_last) begin
                for (int i = 0; i < M_COUNT; i++) begin
                    if (out_sel == DEST_WIDTH'(i)) begin
                        frame_cnt[i] <= frame_cnt[i] + 32'd1;
                    end
                end
            end
            if (accept && (state == IDLE) && !dest_ok) begin
                stat_drops <= stat_drops + 32'd1;
            end
        end
    end

    always_comb begin
        stat_frames = '0;
        for (int i = 0; i < M_COUNT; i++) begin
            stat_frames[i*32 +: 32] = frame_cnt[i];
        end
    end
`endif

endmodule

// File: doc/rmt_dest_demux.md
Name: rmt_dest_demux

Overview:
- Sits directly downstream of the RMT match stage and consumes its AXI-Stream output plus per-frame m_axis_tdest.
- Latches tdest on the first beat of each frame and steers the whole frame to one of M_COUNT output streams.
- Silently drops frames whose dest is out of range.
- Single registered output stage, 1-cycle latency, full throughput (one beat per clock) when the selected output is ready.

Parameters:
- DATA_WIDTH, 512, tdata width in bits
- KEEP_WIDTH, (DATA_WIDTH+7)/8, tkeep width
- USER_WIDTH, 8, tuser width
- DEST_WIDTH, 2, tdest width
- M_COUNT, 4, number of output streams (2..2**DEST_WIDTH)

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- s_axis_tdata  in  DATA_WIDTH  input beat data
- s_axis_tkeep  in  KEEP_WIDTH  input byte enables
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  input end of frame
- s_axis_tuser  in  USER_WIDTH  input sideband
- s_axis_tdest  in  DEST_WIDTH  destination; sampled only on the first beat of a frame
- m_axis_tdata  out  M_COUNT*DATA_WIDTH  per-output data (same beat replicated to every slice)
- m_axis_tkeep  out  M_COUNT*KEEP_WIDTH  per-output keep
- m_axis_tvalid  out  M_COUNT  per-output valid; at most one bit set
- m_axis_tready  in  M_COUNT  per-output ready
- m_axis_tlast  out  M_COUNT  per-output last
- m_axis_tuser  out  M_COUNT*USER_WIDTH  per-output user

Behaviour:
- Reset (rst==0 at a clock edge):
  - state=IDLE; output register empty.
  - All m_axis_tvalid=0, all tdata/tkeep/tlast/tuser=0.
  - s_axis_tready=0 while rst==0.
  - Applies mid-frame: any partial frame is abandoned and the next accepted beat is treated as a first beat.
- Output register: out_valid, out_sel, beat payload.
  - m_axis_tvalid[i] = out_valid && out_sel==i.
  - Payload appears on every slice.
- Handshakes:
  - Input accept = s_axis_tvalid && s_axis_tready.
  - Output pop = out_valid && m_axis_tready[out_sel].
- States:
  - IDLE (awaiting first beat):
    - s_axis_tready = !out_valid || m_axis_tready[out_sel].
    - On accept with s_axis_tdest < M_COUNT: load register with out_sel=s_axis_tdest and latch cur_sel. If !tlast go to FWD; if tlast stay in IDLE (single-beat frame).
    - On accept with s_axis_tdest >= M_COUNT: nothing is loaded (register pops normally). If !tlast go to DROP; if tlast stay in IDLE.
  - FWD:
    - s_axis_tready = !out_valid || m_axis_tready[out_sel].
    - Each accepted beat loads the register with out_sel=cur_sel.
    - s_axis_tdest is ignored mid-frame.
    - Accepted tlast goes to IDLE.
  - DROP:
    - s_axis_tready=1; beats are discarded and the register is not loaded.
    - Accepted tlast goes to IDLE.
- Register update:
  - Pop and load in the same cycle: register replaced, out_valid stays 1.
  - Pop only: out_valid=0.
  - Load only: out_valid=1.
- Latency: an accepted beat is visible on the outputs at the next clock edge.
- Backpressure: the selected output's tready stalls the input. Ready of non-selected outputs has no effect; there is no head-of-line bypass.
- Frame boundary to a different output:
  - The first beat of frame B (to port j) is accepted in the same cycle frame A's last beat pops on port i.
  - The register then presents B on j.
- Output signals remain stable while valid && !ready (AXI-S rule).

Optional Feature:
- Macro: RMT_DEMUX_STATS_EN.
- When defined, adds output ports:
  - stat_frames, M_COUNT*32: per-output count of frames whose tlast popped.
  - stat_drops, 32: count of dropped frames, incremented on the first beat of an out-of-range frame.
- Counters are 32-bit and wrap at 2**32-1 to 0.
- Counters are cleared by reset.
- When not defined: ports absent, no counter logic.

Test Plan:
- 3-beat frame, tdest=1, all ready=1 -> m_axis_tvalid=4'b0010 for 3 consecutive cycles starting 1 cycle after first accept; tlast on third; data matches.
- Single-beat frame tdest=2, then single-beat frame tdest=0 in back-to-back cycles -> tvalid=4'b0100 then 4'b0001, no bubble.
- Frame on port 3 with m_axis_tready[3] held 0 for 5 cycles mid-frame -> s_axis_tready=0 during stall; output beat held stable; no beat lost or duplicated; m_axis_tready[0..2] toggling has no effect.
- M_COUNT=3, 4-beat frame with tdest=3 -> s_axis_tready=1 throughout, no m_axis_tvalid asserted; stat_drops=1 (with RMT_DEMUX_STATS_EN); next frame tdest=0 forwarded normally.
- tdest changed from 1 to 2 on beat 2 of a 3-beat frame -> all 3 beats exit on port 1.
- rst=0 for one cycle during beat 2 of a 4-beat frame -> next cycle all tvalid=0, counters 0; next accepted beat is routed by its own tdest as a new frame.
